// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad front end: column scan, row synchroniser, snapshot debounce
// and one-cycle key-code emission for the lock's user input.
module keypad_scanner #(
  parameter int SCAN_DIV       = 2500,
  parameter int DEBOUNCE_SCANS = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [7:0] DEB_MAX = 8'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DEBOUNCE,
    ST_HELD,
    ST_RELEASE
  } state_t;

  logic [3:0]       row_s1_q, row_s2_q;
  logic [DIV_W-1:0] div_q;
  logic [1:0]       col_q;
  logic [3:0]       col_out_q;
  logic [15:0]      snap_q;
  logic             scan_done_q;

  state_t           state_q;
  logic [7:0]       cnt_q;
  logic [7:0]       cnt_d;
  logic [3:0]       cand_q;
  logic [3:0]       key_code_q;
  logic             key_valid_q;
  logic             key_held_q;

  logic [4:0]       hit_cnt;
  logic [3:0]       single_key;
  logic             is_none;
  logic             is_single;
  logic [4:0]       single_map;
  logic [4:0]       cand_map;

  // Key id is {row, col}; result is {mapped, code}.
  function automatic logic [4:0] map_key(input logic [3:0] key);
    logic [1:0] r;
    logic [1:0] c;
    r = key[3:2];
    c = key[1:0];
    if (c == 2'd3) begin
      return 5'b0_1111;
    end
    if (r == 2'd3) begin
      case (c)
        2'd0:    return 5'b1_1101;
        2'd1:    return 5'b1_0000;
        default: return 5'b1_1110;
      endcase
    end
    return {1'b1, ({2'b00, r} * 4'd3) + {2'b00, c} + 4'd1};
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      row_s1_q <= 4'hF;
      row_s2_q <= 4'hF;
    end else begin
      row_s1_q <= row_in;
      row_s2_q <= row_s1_q;
    end
  end

  // Snapshot bit c*4+r is set when key (r,c) is down.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_q       <= '0;
      col_q       <= 2'd0;
      col_out_q   <= 4'b1110;
      snap_q      <= '0;
      scan_done_q <= 1'b0;
    end else begin
      scan_done_q <= 1'b0;
      if (div_q == DIV_LAST) begin
        div_q                     <= '0;
        col_q                     <= col_q + 2'd1;
        col_out_q                 <= {col_out_q[2:0], col_out_q[3]};
        snap_q[{col_q, 2'b00} +: 4] <= ~row_s2_q;
        if (col_q == 2'd3) begin
          scan_done_q <= 1'b1;
        end
      end else begin
        div_q <= div_q + 1'b1;
      end
    end
  end

  always_comb begin
    hit_cnt    = '0;
    single_key = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (snap_q[c*4 + r]) begin
          hit_cnt    = hit_cnt + 5'd1;
          single_key = {2'(r), 2'(c)};
        end
      end
    end
    is_none    = (hit_cnt == 5'd0);
    is_single  = (hit_cnt == 5'd1);
    single_map = map_key(single_key);
    cand_map   = map_key(cand_q);
    cnt_d      = (cnt_q >= DEB_MAX) ? DEB_MAX : cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 8'd0;
      cand_q      <= 4'd0;
      key_code_q  <= 4'hF;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      key_code_q  <= 4'hF;
      key_valid_q <= 1'b0;
      if (scan_done_q) begin
        case (state_q)
          ST_IDLE: begin
            if (is_single) begin
              cand_q <= single_key;
              if (DEB_MAX <= 8'd1) begin
                state_q    <= ST_HELD;
                cnt_q      <= 8'd0;
                key_held_q <= 1'b1;
                if (single_map[4]) begin
                  key_code_q  <= single_map[3:0];
                  key_valid_q <= 1'b1;
                end
              end else begin
                state_q <= ST_DEBOUNCE;
                cnt_q   <= 8'd1;
              end
            end
          end
          ST_DEBOUNCE: begin
            if (is_single && single_key == cand_q) begin
              if (cnt_d >= DEB_MAX) begin
                state_q    <= ST_HELD;
                cnt_q      <= 8'd0;
                key_held_q <= 1'b1;
                if (cand_map[4]) begin
                  key_code_q  <= cand_map[3:0];
                  key_valid_q <= 1'b1;
                end
              end else begin
                cnt_q <= cnt_d;
              end
            end else begin
              state_q <= ST_IDLE;
              cnt_q   <= 8'd0;
            end
          end
          ST_HELD: begin
            if (is_none) begin
              if (DEB_MAX <= 8'd1) begin
                state_q    <= ST_IDLE;
                cnt_q      <= 8'd0;
                key_held_q <= 1'b0;
              end else begin
                state_q <= ST_RELEASE;
                cnt_q   <= 8'd1;
              end
            end
          end
          default: begin
            // Any key down during release, including multi-key, returns to HELD silently.
            if (is_none) begin
              if (cnt_d >= DEB_MAX) begin
                state_q    <= ST_IDLE;
                cnt_q      <= 8'd0;
                key_held_q <= 1'b0;
              end else begin
                cnt_q <= cnt_d;
              end
            end else begin
              state_q <= ST_HELD;
              cnt_q   <= 8'd0;
            end
          end
        endcase
      end
    end
  end

  assign col_out   = col_out_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: keypad row model, pulse scoreboard and scenario tasks.
module tb_keypad_scanner;

  localparam int SD   = 4;
  localparam int DS   = 3;
  localparam int SCAN = 4 * SD;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  logic [15:0] keys_down = '0;   // bit r*4+c = key (r,c) pressed
  logic [3:0]  exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          pulse_cyc = -1;

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DS)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .row_in   (row_in),
    .col_out  (col_out),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_held (key_held)
  );

  always #5 clk = ~clk;

  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys_down[r*4 + c] && !col_out[c]) row_in[r] = 1'b0;
      end
    end
  end

  always @(posedge clk) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Scoreboard: every pulse must match the oldest expected code.
  always @(negedge clk) begin
    logic [3:0] exp_code;
    if (!rst_n) begin
      pulse_cyc = -1;
    end else if (key_valid) begin
      checks++;
      pulse_cyc = cyc;
      $display("pulse code=%b cyc=%0d", key_code, cyc);
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse got=%b expected=none", key_code);
      end else begin
        exp_code = exp_q.pop_front();
        if (key_code !== exp_code) begin
          errors++;
          $display("FAIL pulse_code got=%b expected=%b", key_code, exp_code);
        end
      end
    end else begin
      checks++;
      if (key_code !== 4'hF) begin
        errors++;
        $display("FAIL idle_code got=%b expected=1111", key_code);
      end
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_missing_pulses got=%0d expected=0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_held(input string name, input logic expv);
    checks++;
    if (key_held !== expv) begin
      errors++;
      $display("FAIL %s_held got=%b expected=%b", name, key_held, expv);
    end
  endtask

  task automatic check_pulse_cyc(input string name, input int expc);
    checks++;
    if (pulse_cyc != expc) begin
      errors++;
      $display("FAIL %s_pulse_cycle got=%0d expected=%0d", name, pulse_cyc, expc);
    end
  endtask

  task automatic test_reset();
    logic [3:0] exp_col;
    keys_down = '0;
    rst_n     = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    checks++;
    if (col_out !== 4'b1110 || key_code !== 4'hF || key_valid !== 1'b0 || key_held !== 1'b0) begin
      errors++;
      $display("FAIL reset_values got=%b/%b/%b/%b expected=1110/1111/0/0",
               col_out, key_code, key_valid, key_held);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    exp_col = 4'b1110;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (col_out !== exp_col) begin
        errors++;
        $display("FAIL col_step%0d got=%b expected=%b", i, col_out, exp_col);
      end
      $display("col step %0d col_out=%b", i, col_out);
      exp_col = {exp_col[2:0], exp_col[3]};
      repeat (SD) @(negedge clk);
    end
  endtask

  task automatic test_press();
    keys_down = 16'd1 << 5;
    exp_q.push_back(4'b0101);
    do_reset(5);
    wait_cycles(10 * SCAN);
    check_pulse_cyc("press5", DS * SCAN + 1);
    check_held("press5_down", 1'b1);
    keys_down = '0;
    wait_cycles(2 * SCAN + 2);
    check_held("press5_releasing", 1'b1);
    wait_cycles(SCAN + 1);
    check_held("press5_released", 1'b0);
    check_drained("press5");
  endtask

  task automatic test_bounce();
    keys_down = 16'd1 << 5;
    do_reset(5);
    wait_cycles(2 * SCAN);
    keys_down = '0;
    wait_cycles(SCAN);
    keys_down = 16'd1 << 5;
    exp_q.push_back(4'b0101);
    wait_cycles(3 * SCAN);
    keys_down = '0;
    wait_cycles(2 * SCAN);
    check_pulse_cyc("bounce", 6 * SCAN + 1);
    check_held("bounce_release", 1'b1);
    keys_down = 16'd1 << 5;
    wait_cycles(3 * SCAN);
    check_held("bounce_repress", 1'b1);
    keys_down = '0;
    wait_cycles(4 * SCAN);
    check_held("bounce_end", 1'b0);
    check_drained("bounce");
  endtask

  task automatic test_special();
    int         idx[5]   = '{13, 12, 14, 10, 3};
    logic [3:0] code[5]  = '{4'b0000, 4'b1101, 4'b1110, 4'b1001, 4'b1111};
    for (int i = 0; i < 5; i++) begin
      keys_down = 16'd1 << idx[i];
      if (code[i] != 4'b1111) exp_q.push_back(code[i]);
      do_reset(5);
      wait_cycles(4 * SCAN);
      check_held($sformatf("special%0d", i), 1'b1);
      check_pulse_cyc($sformatf("special%0d", i), (code[i] != 4'b1111) ? DS * SCAN + 1 : -1);
      keys_down = '0;
      wait_cycles(4 * SCAN);
      check_held($sformatf("special%0d_up", i), 1'b0);
      check_drained($sformatf("special%0d", i));
    end
  endtask

  task automatic test_ghost();
    keys_down = 16'b11;
    do_reset(5);
    wait_cycles(5 * SCAN);
    check_held("ghost_multi", 1'b0);
    check_pulse_cyc("ghost_multi", -1);
    keys_down = 16'b01;
    exp_q.push_back(4'b0001);
    wait_cycles(4 * SCAN);
    check_pulse_cyc("ghost_single", 8 * SCAN + 1);
    keys_down = '0;
    wait_cycles(4 * SCAN);
    check_drained("ghost");
  endtask

  task automatic test_reset_mid();
    keys_down = 16'd1 << 8;
    do_reset(5);
    wait_cycles(2 * SCAN);
    exp_q.push_back(4'b0111);
    do_reset(1);
    wait_cycles(4 * SCAN);
    check_pulse_cyc("reset_mid", DS * SCAN + 1);
    check_held("reset_mid", 1'b1);
    keys_down = '0;
    wait_cycles(4 * SCAN);
    check_drained("reset_mid");
  endtask

  initial begin
    test_reset();
    test_press();
    test_bounce();
    test_special();
    test_ghost();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
